// File: rtl/gamma_mux_scheduler_if.sv
// gamma_mux_scheduler_if: request, shared-mux and result handshake bundle of the gamma scheduler
interface gamma_mux_scheduler_if #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int NUM_INPUTS = GAMMA_CYCLE_WIDTH,
    parameter int SELECT_WIDTH = $clog2(NUM_INPUTS),
    parameter int TIME_WIDTH = $clog2(GAMMA_CYCLE_WIDTH)
);
    logic                    enable;
    logic [NUM_INPUTS-1:0]   req;
    logic                    mux_out;
    logic [SELECT_WIDTH-1:0] select;
    logic                    gamma_start;
    logic                    busy;
    logic                    result_valid;
    logic                    result_ready;
    logic [SELECT_WIDTH-1:0] result_idx;
    logic [TIME_WIDTH-1:0]   result_time;
    logic                    result_hit;

    modport master (
        input  enable, req, mux_out, result_ready,
        output select, gamma_start, busy, result_valid, result_idx, result_time, result_hit
    );

    modport slave (
        output enable, req, mux_out, result_ready,
        input  select, gamma_start, busy, result_valid, result_idx, result_time, result_hit
    );
endinterface

// File: rtl/gamma_mux_scheduler.sv
// gamma_mux_scheduler: grants one requester per gamma window on a shared mux and timestamps its first spike (SCHED_FIXED_PRIORITY_EN selects lowest-index priority instead of round-robin)
module gamma_mux_scheduler #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int NUM_INPUTS = GAMMA_CYCLE_WIDTH,
    parameter int SELECT_WIDTH = $clog2(NUM_INPUTS),
    parameter int TIME_WIDTH = $clog2(GAMMA_CYCLE_WIDTH),
    parameter int MUX_LATENCY = 1
) (
    input logic                   aclk,
    input logic                   grst,
    gamma_mux_scheduler_if.master bus
);
    localparam int WINDOW = GAMMA_CYCLE_WIDTH + MUX_LATENCY;
    localparam int CNT_WIDTH = $clog2(WINDOW);

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    gamma_cnt_q;
    logic [SELECT_WIDTH-1:0] select_q, last_grant_q, idx_q, grant;
    logic [TIME_WIDTH-1:0]   time_q;
    logic                    hit_q, gamma_start_q, have_req, start, spike, last_cnt;

    assign have_req = |bus.req;
    assign start    = have_req && bus.enable &&
                      ((state_q == IDLE) || (state_q == REPORT && bus.result_ready));
    assign last_cnt = gamma_cnt_q == CNT_WIDTH'(WINDOW - 1);
    assign spike    = bus.mux_out && !hit_q && (gamma_cnt_q >= CNT_WIDTH'(MUX_LATENCY));

`ifdef SCHED_FIXED_PRIORITY_EN
    // lowest set request index wins
    always_comb begin
        grant = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--)
            if (bus.req[i]) grant = SELECT_WIDTH'(i);
    end
`else
    logic [SELECT_WIDTH-1:0] rr_base, k;
    logic                    found;
    // in REPORT the result being acknowledged becomes the pointer for a back-to-back grant
    assign rr_base = (state_q == REPORT) ? idx_q : last_grant_q;
    // round-robin search starting just past the previous winner
    always_comb begin
        grant = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 1; i <= NUM_INPUTS; i++) begin
            k = SELECT_WIDTH'((int'(rr_base) + i) % NUM_INPUTS);
            if (!found && bus.req[k]) begin
                grant = k;
                found = 1'b1;
            end
        end
    end
`endif

    // state register
    always_ff @(posedge aclk) begin
        if (grst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last_cnt ? REPORT : RUN;
            REPORT:  state_d = !bus.result_ready ? REPORT : (start ? RUN : IDLE);
            default: state_d = IDLE;
        endcase
    end

    // grant capture, window counter and first-spike timestamp
    always_ff @(posedge aclk) begin
        if (grst) begin
            gamma_cnt_q   <= '0;
            select_q      <= '0;
            idx_q         <= '0;
            time_q        <= '0;
            hit_q         <= 1'b0;
            gamma_start_q <= 1'b0;
            last_grant_q  <= SELECT_WIDTH'(NUM_INPUTS - 1);
        end else begin
            gamma_start_q <= start;
            if (state_q == REPORT && bus.result_ready) last_grant_q <= idx_q;
            if (start) begin
                select_q    <= grant;
                idx_q       <= grant;
                gamma_cnt_q <= '0;
                time_q      <= '0;
                hit_q       <= 1'b0;
            end else if (state_q == RUN) begin
                gamma_cnt_q <= gamma_cnt_q + CNT_WIDTH'(1);
                if (spike) begin
                    hit_q  <= 1'b1;
                    time_q <= TIME_WIDTH'(gamma_cnt_q - CNT_WIDTH'(MUX_LATENCY));
                end
            end
        end
    end

    // outputs
    always_comb begin
        bus.select       = select_q;
        bus.gamma_start  = gamma_start_q;
        bus.busy         = state_q != IDLE;
        bus.result_valid = state_q == REPORT;
        bus.result_idx   = idx_q;
        bus.result_time  = time_q;
        bus.result_hit   = hit_q;
    end
endmodule

// File: doc/gamma_mux_scheduler.md
Name: gamma_mux_scheduler

Overview:
- Sequences a shared temporal 1-of-N select mux across requesting inputs, one gamma cycle per grant.
- Arbitrates among NUM_INPUTS request lines and drives the mux select for a full gamma window.
- Timestamps the first spike seen on the mux output and returns index, time and hit status through a valid/ready result port.
- Sits between the column/neuron request logic and the select input of the mux.

Parameters:
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma window.
- NUM_INPUTS, GAMMA_CYCLE_WIDTH, number of requesters, equal to the number of mux inputs.
- SELECT_WIDTH, $clog2(NUM_INPUTS), width of select and result_idx.
- TIME_WIDTH, $clog2(GAMMA_CYCLE_WIDTH), width of result_time.
- MUX_LATENCY, 1, register stages between a select change and a valid mux_out.

Ports:
- aclk  input  1  clock.
- grst  input  1  reset, synchronous, active-high, sampled on posedge aclk.
- enable  input  1  permits new grants.
- req  input  NUM_INPUTS  per-input service request, level.
- mux_out  input  1  output of the shared mux.
- select  output  SELECT_WIDTH  mux select, registered.
- gamma_start  output  1  one-cycle pulse on the first RUN cycle of each grant.
- busy  output  1  high in RUN and REPORT.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts result.
- result_idx  output  SELECT_WIDTH  granted input index.
- result_time  output  TIME_WIDTH  cycle offset of the first spike.
- result_hit  output  1  a spike was seen in the window.

Behaviour:
- Reset values: all outputs 0. State is IDLE, gamma_cnt is 0, last_grant is NUM_INPUTS-1, so the first round-robin search starts at index 0.
- Grant is round-robin. Search starts at last_grant+1, wraps modulo NUM_INPUTS, and takes the first set req bit.
- IDLE:
  - select holds its last value.
  - If enable && |req: compute grant, register select=grant and gamma_cnt=0, go RUN, assert gamma_start for the next cycle only.
- RUN:
  - gamma_cnt increments each cycle.
  - The window is GAMMA_CYCLE_WIDTH+MUX_LATENCY cycles.
  - mux_out is ignored while gamma_cnt < MUX_LATENCY.
  - On the first cycle with mux_out=1 and gamma_cnt >= MUX_LATENCY, capture result_time = gamma_cnt-MUX_LATENCY (truncated to TIME_WIDTH) and set hit.
  - Later spikes are ignored.
  - At gamma_cnt == GAMMA_CYCLE_WIDTH+MUX_LATENCY-1, go REPORT.
- REPORT:
  - result_valid=1. result_idx, result_time and result_hit stay stable until the handshake.
  - If hit=0, result_time=0.
  - On result_valid && result_ready: last_grant=result_idx, then clear result_valid.
  - Same edge: if enable && |req, go straight to RUN with the new grant (back-to-back, no IDLE bubble). Otherwise go IDLE.
- Boundaries:
  - req deasserted mid-RUN: the window still completes and reports.
  - enable deasserted mid-RUN: the window completes and reports, then IDLE.
  - A spike on the final window cycle is captured with result_time = GAMMA_CYCLE_WIDTH-1.
  - result_ready held low: stays in REPORT indefinitely, no new grant.
  - grst mid-RUN or mid-REPORT: next edge returns to reset values and the pending result is discarded.
  - Only one requester: it is re-granted each window.

Optional Feature:
- Macro SCHED_FIXED_PRIORITY_EN.
- Defined: grant is the lowest set req index and last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- Reset then req=0x0001, enable=1, spike at gamma_cnt=5, MUX_LATENCY=1 -> select=0, one gamma_start pulse, result_valid after 17 RUN cycles with idx=0, time=4, hit=1.
- req=0x0011 held, result_ready=1 -> grants alternate 0,4,0,4, consecutive windows back-to-back with no IDLE cycle.
- req=0x8000, mux_out never high -> idx=15, hit=0, time=0.
- Spikes at gamma_cnt 3 and 9 -> time=2 (first spike only). Spike at gamma_cnt 0 alone -> hit=0.
- result_ready=0 for 10 cycles in REPORT -> outputs stable, no gamma_start. Then ready=1 -> new grant on the handshake edge.
- grst asserted mid-RUN at gamma_cnt=7 -> next cycle all outputs 0. After release, the grant restarts at index 0.
